// File: rtl/quad_stim_pkg.sv
// ---------------------------------------------------------------------------
// quad_stim_pkg
//   Shared types and default constants for the quad_toggle_stim stimulus
//   source and its toggle_div channel dividers.
//
//   Contents:
//     state_e          run controller state encoding (2 bits)
//     CNT_W_DEF        default width of all internal counters
//     P0_DEF..P3_DEF   default half-periods of channels a..d, in clock cycles
//     RUN_CYCLES_DEF   default burst length, in clock cycles
// ---------------------------------------------------------------------------
package quad_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CNT_W_DEF      = 16;
    localparam int P0_DEF         = 5;
    localparam int P1_DEF         = 10;
    localparam int P2_DEF         = 15;
    localparam int P3_DEF         = 20;
    localparam int RUN_CYCLES_DEF = 100;

endpackage : quad_stim_pkg

// File: rtl/toggle_div.sv
// ---------------------------------------------------------------------------
// toggle_div
//   One square-wave channel. While en is high the counter advances once per
//   clock; when it reaches PERIOD-1 the output toggles and the counter
//   restarts, so q has a half-period of PERIOD clocks. The first toggle after
//   a clear lands on the PERIOD-th enabled edge.
//
//   Ports:
//     clk    in   system clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     clr    in   synchronous clear of counter and q (wins over en)
//     en     in   advance the counter this cycle
//     q      out  registered square-wave output
// ---------------------------------------------------------------------------
module toggle_div
    import quad_stim_pkg::*;
#(
    parameter int PERIOD = P0_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic q
);

    // Terminal count, compared at full counter width.
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             q_q;
    logic             q_d;
    logic             at_term;

    assign at_term = (cnt_q == TERM_CNT);

    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (clr) begin
            cnt_d = '0;
            q_d   = 1'b0;
        end else if (en) begin
            if (at_term) begin
                cnt_d = '0;
                q_d   = ~q_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule : toggle_div

// File: rtl/quad_toggle_stim.sv
// ---------------------------------------------------------------------------
// quad_toggle_stim
//   Clocked stimulus source for a 4-input gate block. Four toggle_div
//   channels drive a..d as independent square waves. A run controller
//   bounds each burst to RUN_CYCLES clocks, then pulses done for one cycle.
//
//   State table:
//     IDLE | waiting for start; outputs hold their last values
//     RUN  | channels advance, cycle_cnt counts; busy=1
//     DONE | one-cycle completion, done=1; returns to IDLE unconditionally
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     start      in   level-sampled burst request (IDLE only)
//     stop       in   level-sampled abort; wins over start and completion
//     a,b,c,d    out  stimulus to gate inputs a..d
//     busy       out  high while in RUN
//     done       out  one-cycle pulse at normal completion
//     cycle_cnt  out  RUN cycles elapsed in the current or last burst
// ---------------------------------------------------------------------------
module quad_toggle_stim
    import quad_stim_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int P0         = P0_DEF,
    parameter int P1         = P1_DEF,
    parameter int P2         = P2_DEF,
    parameter int P3         = P3_DEF,
    parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [CNT_W-1:0] RUN_LIM  = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam int               PER [4]  = '{P0, P1, P2, P3};

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_d;

    logic             div_clr;
    logic             div_en;
    logic [3:0]       div_q;

    // Saturating increment; the controller leaves RUN before the limit is
    // passed, the guard only keeps cycle_cnt pinned if that ever changes.
    assign cycle_cnt_d = (cycle_cnt_q == RUN_LIM) ? cycle_cnt_q
                                                  : cycle_cnt_q + CNT_W'(1);

    // Channel control. A stop in RUN suppresses the channel update on the
    // abort edge so the outputs freeze at their pre-edge values.
    always_comb begin
        div_clr = 1'b0;
        div_en  = 1'b0;
        case (state_q)
            IDLE:    div_clr = start && !stop;
            RUN:     div_en  = !stop;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        cycle_cnt_q <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_d;
                        if (cycle_cnt_q == RUN_LAST) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        toggle_div #(
            .PERIOD (PER[i]),
            .CNT_W  (CNT_W)
        ) u_div (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (div_clr),
            .en    (div_en),
            .q     (div_q[i])
        );
    end

    assign a         = div_q[0];
    assign b         = div_q[1];
    assign c         = div_q[2];
    assign d         = div_q[3];
    assign busy      = busy_q;
    assign done      = done_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule : quad_toggle_stim

// File: tb/tb_quad_toggle_stim.sv
module tb_quad_toggle_stim;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        a, b, c, d, busy, done;
    logic [15:0] cycle_cnt;

    logic        e_start = 1'b0;
    logic        e_stop = 1'b0;
    logic        e_a, e_b, e_c, e_d, e_busy, e_done;
    logic [15:0] e_cycle_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    quad_toggle_stim u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .busy      (busy),
        .done      (done),
        .cycle_cnt (cycle_cnt)
    );

    quad_toggle_stim #(.P0(1), .RUN_CYCLES(1)) u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (e_start),
        .stop      (e_stop),
        .a         (e_a),
        .b         (e_b),
        .c         (e_c),
        .d         (e_d),
        .busy      (e_busy),
        .done      (e_done),
        .cycle_cnt (e_cycle_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {d, c, b, a};
    endfunction

    // Full default burst with re-pulsed start in RUN and in DONE.
    task automatic run_burst(input string tag);
        int         tog  [4];
        int         rise [4];
        int         afall;
        int         busy_n;
        int         done_n;
        int         done_at;
        logic [3:0] prev;
        logic [3:0] cur;
        for (int i = 0; i < 4; i++) begin
            tog[i]  = 0;
            rise[i] = -1;
        end
        afall   = -1;
        done_n  = 0;
        done_at = -1;

        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_entry_busy"}, 32'(busy), 32'd1);
        chk({tag, "_entry_clr"}, 32'(outs()), 32'd0);
        chk({tag, "_entry_cnt"}, 32'(cycle_cnt), 32'd0);
        busy_n = 32'(busy);
        prev   = outs();

        for (int n = 1; n <= 100; n++) begin
            start = (n == 50);
            step();
            cur = outs();
            for (int i = 0; i < 4; i++) begin
                if (cur[i] != prev[i]) begin
                    tog[i]++;
                    if (cur[i] && rise[i] < 0) rise[i] = n;
                    if (i == 0 && !cur[i] && afall < 0) afall = n;
                end
            end
            prev = cur;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = n;
            end
        end
        start = 1'b0;

        chk({tag, "_tog_a"}, 32'(tog[0]), 32'd20);
        chk({tag, "_tog_b"}, 32'(tog[1]), 32'd10);
        chk({tag, "_tog_c"}, 32'(tog[2]), 32'd6);
        chk({tag, "_tog_d"}, 32'(tog[3]), 32'd5);
        chk({tag, "_rise_a"}, 32'(rise[0]), 32'd5);
        chk({tag, "_rise_b"}, 32'(rise[1]), 32'd10);
        chk({tag, "_rise_c"}, 32'(rise[2]), 32'd15);
        chk({tag, "_rise_d"}, 32'(rise[3]), 32'd20);
        chk({tag, "_fall_a"}, 32'(afall), 32'd10);
        chk({tag, "_final_out"}, 32'(outs()), 32'b1000);
        chk({tag, "_cnt_end"}, 32'(cycle_cnt), 32'd100);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd100);
        chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
        chk({tag, "_done_at"}, 32'(done_at), 32'd100);

        // start presented while in DONE must not restart
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_after_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_after_done_busy"}, 32'(busy), 32'd0);
        step();
        chk({tag, "_no_restart_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hold_out"}, 32'(outs()), 32'b1000);
        chk({tag, "_hold_cnt"}, 32'(cycle_cnt), 32'd100);
    endtask

    initial begin
        int done_seen;

        // reset state
        repeat (3) step();
        chk("rst_out", 32'(outs()), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(cycle_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // stop wins over start in IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("prio_busy", 32'(busy), 32'd0);
        step();
        chk("prio_busy2", 32'(busy), 32'd0);

        // two identical bursts back to back
        run_burst("b1");
        run_burst("b2");

        // abort at RUN cycle 42
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (42) step();
        chk("abort_pre_cnt", 32'(cycle_cnt), 32'd42);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cnt", 32'(cycle_cnt), 32'd42);
        chk("abort_out", 32'(outs()), 32'd0);
        done_seen = 32'(done);
        repeat (5) begin
            step();
            if (done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_cnt_hold", 32'(cycle_cnt), 32'd42);
        chk("abort_busy_hold", 32'(busy), 32'd0);

        // asynchronous reset at RUN cycle 37
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (37) step();
        chk("pre_rst_out", 32'(outs()), 32'b1011);
        chk("pre_rst_cnt", 32'(cycle_cnt), 32'd37);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 32'(outs()), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_cnt", 32'(cycle_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);

        // P0=1, RUN_CYCLES=1 instance
        e_start = 1'b1;
        step();
        e_start = 1'b0;
        chk("edge_busy", 32'(e_busy), 32'd1);
        chk("edge_a0", 32'(e_a), 32'd0);
        step();
        chk("edge_a1", 32'(e_a), 32'd1);
        chk("edge_done", 32'(e_done), 32'd1);
        chk("edge_busy_off", 32'(e_busy), 32'd0);
        chk("edge_cnt", 32'(e_cycle_cnt), 32'd1);
        step();
        chk("edge_done_off", 32'(e_done), 32'd0);
        chk("edge_a_hold", 32'(e_a), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_quad_toggle_stim

// File: doc/quad_toggle_stim.md
Name: quad_toggle_stim

Overview:
- Synthesizable stimulus source directly upstream of the 4-input gate block (inputs a, b, c, d; outputs e, f, g).
- Drives the gate's four inputs as independent square waves, each with its own programmable half-period in clock cycles.
- A run controller bounds each stimulus burst to a fixed cycle count, then signals completion.
- Replaces free-running delay-based toggling with a clocked, resettable, repeatable source usable on the board and in simulation.

Parameters:
- CNT_W, 16, width of all internal counters.
- P0, 5, half-period of a, in clock cycles (≥1).
- P1, 10, half-period of b, in clock cycles (≥1).
- P2, 15, half-period of c, in clock cycles (≥1).
- P3, 20, half-period of d, in clock cycles (≥1).
- RUN_CYCLES, 100, length of one burst, in clock cycles (≥1, < 2^CNT_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level-sampled request to begin a burst.
- stop  input  1  level-sampled abort request.
- a  output  1  stimulus to gate input a.
- b  output  1  stimulus to gate input b.
- c  output  1  stimulus to gate input c.
- d  output  1  stimulus to gate input d.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse at normal burst completion.
- cycle_cnt  output  CNT_W  RUN cycles elapsed in the current or last burst.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; a=b=c=d=0; busy=0; done=0; cycle_cnt=0; channel counters=0. Reset mid-burst aborts immediately, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and stop=0 → RUN at the next edge. On that edge: a..d←0, all channel counters←0, cycle_cnt←0.
  - stop=1 (with or without start) → stay in IDLE; stop wins.
  - Outputs hold their last values while in IDLE.
- RUN (busy=1):
  - Each channel i, every edge: if cnt_i==Pi-1 then out_i toggles and cnt_i←0, else cnt_i←cnt_i+1.
  - The first toggle of channel i occurs on the Pi-th edge after entering RUN. Pi=1 toggles every cycle.
  - cycle_cnt increments every edge.
  - When cycle_cnt==RUN_CYCLES-1 at an edge → DONE. Channel updates on that same edge still apply. cycle_cnt saturates at RUN_CYCLES.
  - stop=1 → IDLE at the next edge. Outputs and cycle_cnt freeze at their pre-edge values; no toggle or count is applied on that edge; no done pulse.
  - stop=1 on the final cycle: stop wins; no done pulse.
  - start while in RUN is ignored; no restart.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditionally IDLE. Outputs hold. start in DONE is ignored.
- Latency: start sampled at edge k → busy=1 after edge k; done=1 after edge k+RUN_CYCLES.
- Counters are unsigned CNT_W bits. Pi and RUN_CYCLES are compared at full width; wrap never occurs given the parameter limits.
- Outputs are registered, with no combinational path from start or stop.

Decomposition:
- Shared package quad_stim_pkg:
  - state enum {IDLE, RUN, DONE} (2-bit encoding).
  - CNT_W default.
  - Default half-period constants.
- One sub-module, toggle_div, instantiated 4 times.
  - Parameters: PERIOD, CNT_W.
  - Ports: clk, rst_n, clr, en, q.
  - clr zeroes the counter and q; en advances the counter.
- The top level holds the FSM and cycle_cnt, and drives clr/en to the four instances.

Test Plan:
- Reset: assert rst_n=0 mid-RUN at cycle 37 → same-timestep a..d=0, busy=0, cycle_cnt=0, state IDLE, no done.
- Full default burst: start pulse → busy for 100 cycles.
  - Toggle counts: a 20, b 10, c 6, d 5.
  - Final values a=0, b=0, c=0, d=1.
  - cycle_cnt=100, done high for exactly 1 cycle, then IDLE.
- Toggle timing: after start, a rises on the 5th RUN edge, b on the 10th, c on the 15th, d on the 20th; a falls on the 10th.
- Abort: stop=1 at RUN cycle 42 → IDLE next edge, busy=0, done never asserts, outputs frozen, cycle_cnt=42.
- Priority and ignore:
  - start=stop=1 in IDLE → remains IDLE.
  - start re-pulsed during RUN and during DONE → no restart; burst still ends at 100.
- Restart and edge parameters:
  - Second start after DONE → a..d cleared to 0 on entry; the second burst is identical to the first.
  - Rebuild with P0=1, RUN_CYCLES=1 → a=1 after one RUN cycle, done pulses the next cycle.
